// File: rtl/tdc_event_builder.sv
// TDC event builder: encodes start/stop one-hot fine codes, pairs them with the coarse
// count and queues tap-unit intervals in a small FIFO. Optional stats: TDC_EVENT_STATS_EN.

module tdc_onehot_enc #(
    parameter int N_TAPS = 172,
    parameter int IDX_W  = 8
) (
    input  logic [N_TAPS-1:0] code,
    output logic [IDX_W-1:0]  idx,
    output logic              nz,
    output logic              bubble
);
    // Downward scan so the lowest set bit is the last write.
    always_comb begin
        idx = '0;
        for (int i = N_TAPS - 1; i >= 0; i--)
            if (code[i]) idx = IDX_W'(i);
    end

    assign nz     = |code;
    assign bubble = |(code & (code - N_TAPS'(1)));
endmodule

module tdc_event_builder #(
    parameter int N_TAPS       = 172,
    parameter int IDX_W        = 8,
    parameter int COARSE_W     = 48,
    parameter int CLK_BINS     = 176,
    parameter int RES_W        = 56,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_TAPS-1:0]   one_hot_start,
    input  logic [N_TAPS-1:0]   one_hot_stop,
    input  logic [COARSE_W-1:0] out_count,
    output logic [RES_W-1:0]    res_interval,
    output logic [2:0]          res_flags,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                overflow,
    output logic                timeout,
    output logic [15:0]         stat_events,
    output logic [15:0]         stat_errors
);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_STOP, CALC, PUSH} state_t;

    typedef struct packed {
        logic [2:0]       flags;     // {neg_clamp, bubble_stop, bubble_start}
        logic [RES_W-1:0] interval;
    } res_t;

    // Index 0 = start, 1 = stop.
    logic [1:0][N_TAPS-1:0] code;
    logic [1:0][IDX_W-1:0]  idx;
    logic [1:0]             nz, bub;

    assign code = {one_hot_stop, one_hot_start};

    for (genvar g = 0; g < 2; g++) begin : g_enc
        tdc_onehot_enc #(.N_TAPS(N_TAPS), .IDX_W(IDX_W)) u_enc (
            .code(code[g]), .idx(idx[g]), .nz(nz[g]), .bubble(bub[g])
        );
    end

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q;
    logic [IDX_W-1:0]    start_idx_q, stop_idx_q;
    logic                bstart_q, bstop_q;
    logic [COARSE_W-1:0] count_q;
    res_t                calc_q;
    logic                latch_start, latch_stop, timeout_d, ovf_d, push_ok;

    always_comb begin
        state_d     = state_q;
        latch_start = 1'b0;
        latch_stop  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: if (nz[0]) begin
                latch_start = 1'b1;
                if (nz[1]) begin
                    latch_stop = 1'b1;
                    state_d    = CALC;
                end else begin
                    state_d    = WAIT_STOP;
                end
            end
            WAIT_STOP: if (nz[1]) begin
                latch_stop = 1'b1;
                state_d    = CALC;
            end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
                timeout_d  = 1'b1;
                state_d    = IDLE;
            end
            CALC:    state_d = PUSH;
            default: state_d = IDLE;
        endcase
    end

    // One extra bit keeps the sign of a stop tap that outruns the coarse term.
    logic [RES_W:0] sum;
    logic           neg;
    assign sum = (RES_W+1)'(count_q) * (RES_W+1)'(CLK_BINS)
               + (RES_W+1)'(start_idx_q) - (RES_W+1)'(stop_idx_q);
    assign neg = sum[RES_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            start_idx_q <= '0;
            stop_idx_q  <= '0;
            bstart_q    <= 1'b0;
            bstop_q     <= 1'b0;
            count_q     <= '0;
            calc_q      <= '0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timeout  <= timeout_d;
            overflow <= ovf_d;
            timer_q  <= (state_q == WAIT_STOP) ? timer_q + TW'(1) : '0;
            if (latch_start) begin
                start_idx_q <= idx[0];
                bstart_q    <= bub[0];
            end
            if (latch_stop) begin
                stop_idx_q <= idx[1];
                bstop_q    <= bub[1];
                count_q    <= out_count;
            end
            if (state_q == CALC)
                calc_q <= '{flags: {neg, bstop_q, bstart_q},
                            interval: neg ? '0 : sum[RES_W-1:0]};
        end
    end

    assign busy = (state_q != IDLE);

    // Storage ring feeds a registered head; occupancy counts both toward FIFO_DEPTH.
    res_t          mem [FIFO_DEPTH];
    res_t          head_q;
    logic [PW:0]   wr_ptr_q, rd_ptr_q, mem_cnt, occ;
    logic          full, pop, xfer;

    assign pop     = res_valid & res_ready;
    assign mem_cnt = wr_ptr_q - rd_ptr_q;
    assign occ     = mem_cnt + (PW+1)'(res_valid);
    assign full    = (occ == (PW+1)'(FIFO_DEPTH));
    assign push_ok = (state_q == PUSH) && (!full || pop);
    assign ovf_d   = (state_q == PUSH) && full && !pop;
    assign xfer    = (mem_cnt != '0) && (!res_valid || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[PW-1:0]] <= calc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            res_valid <= 1'b0;
            head_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (xfer) begin
                head_q    <= mem[rd_ptr_q[PW-1:0]];
                rd_ptr_q  <= rd_ptr_q + (PW+1)'(1);
                res_valid <= 1'b1;
            end else if (pop) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign res_interval = head_q.interval;
    assign res_flags    = head_q.flags;

`ifdef TDC_EVENT_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_events <= '0;
            stat_errors <= '0;
        end else begin
            if (push_ok && stat_events != 16'hFFFF) stat_events <= stat_events + 16'd1;
            if ((ovf_d || timeout_d) && stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
        end
    end
`else
    assign stat_events = '0;
    assign stat_errors = '0;
`endif
endmodule

// File: tb/tb_tdc_event_builder.sv
// Directed self-checking bench for tdc_event_builder; honours TDC_EVENT_STATS_EN.

module tb_tdc_event_builder;
    logic          clk = 1'b0;
    logic          reset;
    logic [171:0]  one_hot_start, one_hot_stop;
    logic [47:0]   out_count;
    logic [55:0]   res_interval;
    logic [2:0]    res_flags;
    logic          res_valid, res_ready, busy, overflow, timeout;
    logic [15:0]   stat_events, stat_errors;
    int            checks = 0;
    int            errors = 0;

`ifdef TDC_EVENT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    tdc_event_builder dut (
        .clk(clk), .reset(reset),
        .one_hot_start(one_hot_start), .one_hot_stop(one_hot_stop),
        .out_count(out_count),
        .res_interval(res_interval), .res_flags(res_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .overflow(overflow), .timeout(timeout),
        .stat_events(stat_events), .stat_errors(stat_errors)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [171:0] oh(input int b);
        logic [171:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Apply start/stop together; returns with FSM back in IDLE and the result written (or dropped).
    task automatic ev(input logic [171:0] s, input logic [171:0] p, input logic [47:0] c);
        one_hot_start = s;
        one_hot_stop  = p;
        out_count     = c;
        step();
        one_hot_start = '0;
        one_hot_stop  = '0;
        step();
        step();
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b0; one_hot_start = '0; one_hot_stop = '0; out_count = '0; res_ready = 1'b0;
        step(); step();
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_interval", 64'(res_interval), 64'd0);
        chk("rst_flags", 64'(res_flags), 64'd0);
        chk("rst_pulses", 64'({overflow, timeout}), 64'd0);
        chk("rst_stats", 64'({stat_events, stat_errors}), 64'd0);
        reset = 1'b1;
        step();

        // 1: start 10, stop 40 five cycles later, count 3 -> 3*176+10-40 = 498
        one_hot_start = oh(10);
        step();
        one_hot_start = '0;
        chk("t1_busy_wait", 64'(busy), 64'd1);
        repeat (4) step();
        one_hot_stop = oh(40); out_count = 48'd3;
        step();                       // stop captured (T)
        one_hot_stop = '0; out_count = 48'd99;
        chk("t1_valid_T", 64'(res_valid), 64'd0);
        step();
        chk("t1_valid_T1", 64'(res_valid), 64'd0);
        step();
        chk("t1_valid_T2", 64'(res_valid), 64'd0);
        chk("t1_busy_T2", 64'(busy), 64'd0);
        step();
        chk("t1_valid_T3", 64'(res_valid), 64'd1);
        chk("t1_interval", 64'(res_interval), 64'd498);
        chk("t1_flags", 64'(res_flags), 64'd0);
        pop_one();
        chk("t1_popped", 64'(res_valid), 64'd0);
        chk("t1_stat_events", 64'(stat_events), STATS ? 64'd1 : 64'd0);

        // 2: same-cycle pair, then a negative result that clamps
        ev(oh(100), oh(20), 48'd0);
        step();
        chk("t2a_interval", 64'(res_interval), 64'd80);
        chk("t2a_flags", 64'(res_flags), 64'd0);
        pop_one();
        ev(oh(5), oh(20), 48'd0);
        step();
        chk("t2b_interval", 64'(res_interval), 64'd0);
        chk("t2b_flags", 64'(res_flags), 64'b100);
        pop_one();

        // 3: bubbled start (bits 12,13), and bubbled stop (bits 3,7)
        ev(oh(12) | oh(13), oh(0), 48'd1);
        step();
        chk("t3a_interval", 64'(res_interval), 64'd188);
        chk("t3a_flags", 64'(res_flags), 64'b001);
        pop_one();
        ev(oh(50), oh(3) | oh(7), 48'd0);
        step();
        chk("t3b_interval", 64'(res_interval), 64'd47);
        chk("t3b_flags", 64'(res_flags), 64'b010);
        pop_one();

        // 4: timeout; pulse appears after the 1024th edge following start capture
        one_hot_start = oh(7);
        step();
        one_hot_start = '0;
        k = 0;
        while (timeout !== 1'b1 && k < 2000) begin
            step();
            k++;
        end
        chk("t4_timeout_cycle", 64'(k), 64'd1024);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_no_write", 64'(res_valid), 64'd0);
        chk("t4_stat_errors", 64'(stat_errors), STATS ? 64'd1 : 64'd0);
        chk("t4_stat_events", 64'(stat_events), STATS ? 64'd5 : 64'd0);
        step();
        chk("t4_pulse_once", 64'(timeout), 64'd0);
        step(); step();
        chk("t4_still_empty", 64'(res_valid), 64'd0);

        // 4b: stop on the final timer cycle beats timeout -> 2*176+30-10 = 372
        one_hot_start = oh(30);
        step();
        one_hot_start = '0;
        repeat (1023) step();
        one_hot_stop = oh(10); out_count = 48'd2;
        step();
        one_hot_stop = '0;
        chk("t4b_no_timeout", 64'(timeout), 64'd0);
        chk("t4b_busy", 64'(busy), 64'd1);
        step(); step(); step();
        chk("t4b_interval", 64'(res_interval), 64'd372);
        pop_one();

        // 5: fill FIFO, overflow on 5th, push+pop while full on 6th, then drain in order
        for (int i = 1; i <= 4; i++) begin
            ev(oh(1), oh(1), 48'(i));
            chk("t5_no_ovf", 64'(overflow), 64'd0);
        end
        ev(oh(1), oh(1), 48'd5);
        chk("t5_ovf", 64'(overflow), 64'd1);
        step();
        chk("t5_ovf_pulse", 64'(overflow), 64'd0);
        chk("t5_head", 64'(res_interval), 64'd176);
        one_hot_start = oh(1); one_hot_stop = oh(1); out_count = 48'd6;
        step();
        one_hot_start = '0; one_hot_stop = '0;
        step();
        res_ready = 1'b1;
        step();                       // push while full, with pop
        res_ready = 1'b0;
        chk("t5_full_pushpop", 64'(overflow), 64'd0);
        chk("t5_head2", 64'(res_interval), 64'd352);
        pop_one();
        chk("t5_head3", 64'(res_interval), 64'd528);
        pop_one();
        chk("t5_head4", 64'(res_interval), 64'd704);
        pop_one();
        chk("t5_head6", 64'(res_interval), 64'd1056);
        chk("t5_valid_last", 64'(res_valid), 64'd1);
        pop_one();
        chk("t5_drained", 64'(res_valid), 64'd0);
        step();
        chk("t5_hold", 64'(res_interval), 64'd1056);
        chk("t5_stat_events", 64'(stat_events), STATS ? 64'd11 : 64'd0);
        chk("t5_stat_errors", 64'(stat_errors), STATS ? 64'd2 : 64'd0);

        // 6: reset in WAIT_STOP with two queued results
        ev(oh(2), oh(1), 48'd1);
        ev(oh(2), oh(1), 48'd2);
        one_hot_start = oh(9);
        step();
        one_hot_start = '0;
        chk("t6_pre_busy", 64'(busy), 64'd1);
        chk("t6_pre_valid", 64'(res_valid), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_valid", 64'(res_valid), 64'd0);
        chk("t6_interval", 64'(res_interval), 64'd0);
        chk("t6_stats", 64'({stat_events, stat_errors}), 64'd0);
        one_hot_stop = oh(3); out_count = 48'd5;
        step();
        one_hot_stop = '0;
        step(); step(); step();
        chk("t6_no_stale", 64'(res_valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        ev(oh(4), oh(4), 48'd1);
        step();
        chk("t6_fresh", 64'(res_interval), 64'd176);
        pop_one();
        chk("t6_single", 64'(res_valid), 64'd0);
        chk("t6_stat_events", 64'(stat_events), STATS ? 64'd1 : 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
